mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
Iterative multiply/divide sequencer that executes MULT, MULTU, DIV and DIVU issued from EX and owns the architectural HI/LO registers.
- Runs a WIDTH-cycle shift-add (multiply) or restoring (divide) loop and raises busy so the hazard logic stalls MFHI/MFLO and further MDU ops.
- Also services MTHI/MTLO writes.
- Sits beside the ALU in EX; HI/LO outputs feed the MFHI/MFLO writeback mux.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
start  input  1  issue MDU op this cycle (EX valid and op is MULT/MULTU/DIV/DIVU)
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
src_a  input  WIDTH  rs value (multiplicand/dividend)
src_b  input  WIDTH  rt value (multiplier/divisor)
cancel  input  1  pipeline flush; abort in-flight op
hi_we  input  1  MTHI write
lo_we  input  1  MTLO write
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  registered; op in flight, stall dependents
done  output  1  registered 1-cycle pulse: HI/LO just updated by an op
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst high at edge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operands=0. Overrides start, cancel and writes. Reset mid-op discards the op with no HI/LO update.
- States: IDLE, PREP, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch op, |src_a|, |src_b| (absolute value only for signed ops), sign_q = a[W-1]^b[W-1], sign_r = a[W-1]; go to PREP; busy=1.
  - start=0: hi_we/lo_we write wdata into hi/lo at the edge; both may fire in the same cycle.
  - start and hi_we/lo_we in the same cycle: start wins, write dropped.
- PREP (1 cycle): clear the 2W accumulator, load the counter with WIDTH-1, go to CALC.
- CALC (WIDTH cycles, counter down to 0):
  - Multiply: if multiplier LSB is set, add the multiplicand into the upper half; shift right 1; carry kept in a W+1-bit add.
  - Divide: shift {rem, quo} left 1; trial subtract rem-divisor at W+1 bits; if non-negative, commit and set quo LSB.
  - After counter = 0: go to FIX.
- FIX (1 cycle):
  - Signed multiply with sign_q: negate the 2W product.
  - Signed divide: negate the quotient if sign_q; negate the remainder if sign_r.
  - Write hi/lo (MULT*: hi = upper half, lo = lower half; DIV*: lo = quotient, hi = remainder).
  - Go to IDLE; busy=0 and done=1 after that edge.
- Latency: start at edge E0 → hi/lo updated and done=1 after edge E0+WIDTH+2 (34 edges for WIDTH=32). busy=1 for exactly WIDTH+2 cycles.
- start while busy: ignored; the hazard unit must not issue.
- hi_we/lo_we while busy: ignored; HI/LO are owned by the in-flight op.
- cancel while busy: abort next edge → IDLE, busy=0, done=0, HI/LO unchanged. cancel in IDLE: no effect, and a same-cycle start is also suppressed.
- Divide by zero: loop runs the normal latency, no special case.
  - Unsigned: lo=all ones, hi=src_a.
  - Signed: sign fix-up is applied to those raw values.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0 (falls out of the magnitude path).
- done deasserts the cycle after it pulses. A back-to-back start is legal in the cycle done=1.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002 → after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse 1 cycle, busy high exactly 34 cycles.
- MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE. Also MULTU 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 7/0 → lo=0xFFFFFFFF, hi=0x00000007. MTLO 0x1234 in IDLE → lo=0x1234 next edge. MTHI during busy → ignored.
- Start DIVU, assert cancel at cycle 10 → busy=0 next cycle, no done, hi/lo keep their prior values. A second start during busy is ignored (result matches the first op).
- rst at cycle 20 of a MULT → hi=lo=0, busy=0, done=0. A new op issued afterwards completes correctly.

Source files
------------

// File: rtl/mdu_seq_if.sv
// Issue, move-to and result signals shared between EX and the multiply/divide sequencer.
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: shift-add multiply,
// restoring divide, sign fix-up at the end, plus MTHI/MTLO writes while idle.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    mdu_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam int W2 = 2 * WIDTH;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
        neg_2w = ~v + {{(W2-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sign_q_r;
    logic             sign_rem_r;
    logic [W2-1:0]    acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_trial_s;
    logic [W2-1:0]    acc_step_s;
    logic [W2-1:0]    prod_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] fix_hi_s;
    logic [WIDTH-1:0] fix_lo_s;

    // Operand magnitudes at issue, one loop iteration, and the final sign fix-up.
    always_comb begin
        abs_a_s     = bus.src_a;
        abs_b_s     = bus.src_b;
        acc_step_s  = acc_r;
        prod_s      = acc_r;
        quo_s       = acc_r[WIDTH-1:0];
        rem_s       = acc_r[W2-1:WIDTH];
        fix_hi_s    = acc_r[W2-1:WIDTH];
        fix_lo_s    = acc_r[WIDTH-1:0];

        if (!bus.op[0] && bus.src_a[WIDTH-1]) begin
            abs_a_s = neg_w(bus.src_a);
        end else begin
            abs_a_s = bus.src_a;
        end
        if (!bus.op[0] && bus.src_b[WIDTH-1]) begin
            abs_b_s = neg_w(bus.src_b);
        end else begin
            abs_b_s = bus.src_b;
        end

        // Multiplier sits in the low half and drains out as the partial product shifts in.
        mul_sum_s   = {1'b0, acc_r[W2-1:WIDTH]} + (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        div_trial_s = acc_r[W2-1:WIDTH-1] - {1'b0, b_r};

        if (op_r[1]) begin
            if (!div_trial_s[WIDTH]) begin
                acc_step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = {acc_r[W2-2:0], 1'b0};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end

        if (!op_r[0] && sign_q_r) begin
            prod_s = neg_2w(acc_r);
            quo_s  = neg_w(acc_r[WIDTH-1:0]);
        end else begin
            prod_s = acc_r;
            quo_s  = acc_r[WIDTH-1:0];
        end
        if (!op_r[0] && sign_rem_r) begin
            rem_s = neg_w(acc_r[W2-1:WIDTH]);
        end else begin
            rem_s = acc_r[W2-1:WIDTH];
        end

        if (op_r[1]) begin
            fix_hi_s = rem_s;
            fix_lo_s = quo_s;
        end else begin
            fix_hi_s = prod_s[W2-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Sequencer FSM with registered busy/done and the HI/LO architectural state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            op_r       <= 2'b00;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            sign_q_r   <= 1'b0;
            sign_rem_r <= 1'b0;
            acc_r      <= {W2{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            if (state_r != IDLE && bus.cancel) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (!bus.start) begin
                            if (bus.hi_we) hi_r <= bus.wdata;
                            if (bus.lo_we) lo_r <= bus.wdata;
                        end else if (!bus.cancel) begin
                            op_r       <= bus.op;
                            a_r        <= abs_a_s;
                            b_r        <= abs_b_s;
                            sign_q_r   <= bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
                            sign_rem_r <= bus.src_a[WIDTH-1];
                            busy_r     <= 1'b1;
                            state_r    <= PREP;
                        end
                    end
                    PREP: begin
                        acc_r   <= op_r[1] ? {{WIDTH{1'b0}}, a_r} : {{WIDTH{1'b0}}, b_r};
                        cnt_r   <= CNT_W'(WIDTH - 1);
                        state_r <= CALC;
                    end
                    CALC: begin
                        acc_r <= acc_step_s;
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            state_r <= FIX;
                        end else begin
                            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    FIX: begin
                        hi_r    <= fix_hi_s;
                        lo_r    <= fix_lo_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: multiply/divide results, latency, MTHI/MTLO, cancel and reset.
module tb_mdu_seq;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   bc;
    bit   gd;
    bit   saw_done;

    mdu_seq_if #(.WIDTH(32)) bus ();

    mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents start for the current cycle; returns at the negedge after issue.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts busy cycles until done is seen, bounded.
    task automatic wait_done(output int busy_cycles, output bit got_done);
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = 32'h0;
        bus.src_b = 32'h0;
        bus.cancel = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // MULT -1 * 2
        launch(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(bc, gd);
        chk("mult_done", {31'h0, gd}, 32'h1);
        chk("mult_busy_cycles", bc, 32'd34);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFE);
        @(negedge clk);
        chk("mult_done_pulse", {31'h0, bus.done}, 32'h0);

        // MULTU same operands
        launch(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(bc, gd);
        chk("multu_done", {31'h0, gd}, 32'h1);
        chk("multu_hi", bus.hi, 32'h0000_0001);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFE);
        @(negedge clk);

        // MULTU max * max
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc, gd);
        chk("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", bus.lo, 32'h0000_0001);
        @(negedge clk);

        // DIV -7 / 2
        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(bc, gd);
        chk("div_busy_cycles", bc, 32'd34);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        @(negedge clk);

        // DIV overflow, followed back-to-back by DIVU 7/0 in the done cycle
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(bc, gd);
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);
        chk("div_ovf_hi", bus.hi, 32'h0000_0000);
        launch(2'b11, 32'h0000_0007, 32'h0000_0000);
        chk("b2b_done_low", {31'h0, bus.done}, 32'h0);
        chk("b2b_busy", {31'h0, bus.busy}, 32'h1);
        wait_done(bc, gd);
        chk("divu0_done", {31'h0, gd}, 32'h1);
        chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
        chk("divu0_hi", bus.hi, 32'h0000_0007);
        @(negedge clk);

        // MTLO in idle
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo_lo", bus.lo, 32'h0000_1234);
        chk("mtlo_hi_kept", bus.hi, 32'h0000_0007);

        // DIVU 100/7 with MTHI and a second start injected while busy
        launch(2'b11, 32'd100, 32'd7);
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.src_a = 32'd3;
        bus.src_b = 32'd3;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.start = 1'b0;
        chk("mthi_busy_ignored", bus.hi, 32'h0000_0007);
        wait_done(bc, gd);
        chk("divu_done", {31'h0, gd}, 32'h1);
        chk("divu_lo", bus.lo, 32'd14);
        chk("divu_hi", bus.hi, 32'd2);
        @(negedge clk);
        chk("divu_no_second", {31'h0, bus.busy}, 32'h0);

        // Cancel at cycle 10 of a DIVU
        launch(2'b11, 32'd50, 32'd3);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("cancel_busy", {31'h0, bus.busy}, 32'h0);
        chk("cancel_done", {31'h0, bus.done}, 32'h0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        chk("cancel_no_done", {31'h0, saw_done}, 32'h0);
        chk("cancel_lo_kept", bus.lo, 32'd14);
        chk("cancel_hi_kept", bus.hi, 32'd2);

        // Cancel in idle suppresses a same-cycle start
        bus.cancel = 1'b1;
        launch(2'b01, 32'd5, 32'd5);
        bus.cancel = 1'b0;
        chk("idle_cancel_start", {31'h0, bus.busy}, 32'h0);

        // Reset at cycle 20 of a MULT, then a fresh op
        launch(2'b00, 32'd5, 32'd6);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_hi", bus.hi, 32'h0);
        chk("midrst_lo", bus.lo, 32'h0);
        chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
        chk("midrst_done", {31'h0, bus.done}, 32'h0);
        launch(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(bc, gd);
        chk("post_rst_done", {31'h0, gd}, 32'h1);
        chk("post_rst_hi", bus.hi, 32'hFFFF_FFFF);
        chk("post_rst_lo", bus.lo, 32'hFFFF_FFF1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
